// File: rtl/mipi_rx_frame_ctrl.sv
// Capture controller behind the MIPI CSI-2 RX decoder, PARALLEL_CLOCK_I domain.
// Arms frame capture, forwards accepted pixel beats as a registered stream with
// SOF (tuser) / EOL (tlast) markers, checks frame geometry, runs a stall
// watchdog and exposes sticky errors plus line/frame counters.
// enable_i is the master enable: with enable_i low the controller never waits
// for a frame, so a single-shot arm_i needs enable_i high to take effect.
module mipi_rx_frame_ctrl #(
  parameter int g_DATAWIDTH     = 10,
  parameter int g_NUM_OF_PIXELS = 4,
  parameter int g_HRES          = 1920,
  parameter int g_VRES          = 1080,
  parameter int g_TIMEOUT       = 2000000
) (
  input  logic                                   PARALLEL_CLOCK_I,
  input  logic                                   RESET_n_I,
  input  logic                                   enable_i,
  input  logic                                   single_shot_i,
  input  logic                                   arm_i,
  input  logic                                   clr_err_i,
  input  logic                                   frame_start_i,
  input  logic                                   frame_end_i,
  input  logic                                   line_start_i,
  input  logic                                   line_end_i,
  input  logic                                   line_valid_i,
  input  logic [g_DATAWIDTH*g_NUM_OF_PIXELS-1:0] data_in_i,
  output logic [g_DATAWIDTH*g_NUM_OF_PIXELS-1:0] tdata_o,
  output logic                                   tvalid_o,
  output logic                                   tuser_o,
  output logic                                   tlast_o,
  output logic                                   busy_o,
  output logic                                   frame_done_o,
  output logic                                   err_line_len_o,
  output logic                                   err_line_cnt_o,
  output logic                                   err_timeout_o,
  output logic [15:0]                            line_count_o,
  output logic [15:0]                            frame_count_o
);

  localparam int W     = g_DATAWIDTH * g_NUM_OF_PIXELS;
  localparam int BEATS = g_HRES / g_NUM_OF_PIXELS;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(g_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            sof_pend_q, sof_pend_d;
  logic [W-1:0]    tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tuser_q, tuser_d;
  logic            tlast_q, tlast_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_len_q, err_len_d;
  logic            err_lcnt_q, err_lcnt_d;
  logic            err_to_q, err_to_d;

  // Working values inside ACTIVE: restart, line start, beat, line end applied in order.
  logic [BW-1:0]   beat_v;
  logic [15:0]     line_v;
  logic            sof_v;
  logic            set_len_s, set_lcnt_s, set_to_s;
  logic            cont_s;

  // Next-state, datapath and error-set decode for one cycle.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wd_cnt_d    = '0;
    sof_pend_d  = sof_pend_q;
    tdata_d     = tdata_q;
    tvalid_d    = 1'b0;
    tuser_d     = 1'b0;
    tlast_d     = 1'b0;
    done_d      = 1'b0;
    beat_v      = beat_cnt_q;
    line_v      = line_cnt_q;
    sof_v       = sof_pend_q;
    set_len_s   = 1'b0;
    set_lcnt_s  = 1'b0;
    set_to_s    = 1'b0;
    cont_s      = enable_i & ~single_shot_i;

    case (state_q)
      ST_IDLE: begin
        if (cont_s || arm_i) begin
          state_d = ST_WAIT_FS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_FS: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (frame_start_i) begin
          state_d    = ST_ACTIVE;
          line_cnt_d = 16'd0;
          beat_cnt_d = '0;
          sof_pend_d = 1'b1;
        end else begin
          state_d = ST_WAIT_FS;
        end
      end

      ST_ACTIVE: begin
        // A second frame start inside a frame is a geometry error and restarts it.
        if (frame_start_i) begin
          set_lcnt_s = 1'b1;
          line_v     = 16'd0;
          beat_v     = '0;
          sof_v      = 1'b1;
        end else begin
          sof_v = sof_pend_q;
        end

        if (line_start_i) begin
          beat_v = '0;
        end else begin
          beat_v = beat_v;
        end

        if (line_valid_i) begin
          if (beat_v < BW'(BEATS)) begin
            tvalid_d = 1'b1;
            tdata_d  = data_in_i;
            tuser_d  = sof_v;
            tlast_d  = (beat_v == BW'(BEATS - 1));
            beat_v   = beat_v + BW'(1);
            sof_v    = 1'b0;
          end else begin
            set_len_s = 1'b1;
          end
        end else begin
          tvalid_d = 1'b0;
        end

        // Line end sees the beat delivered in the same cycle.
        if (line_end_i) begin
          if (beat_v < BW'(BEATS)) begin
            set_len_s = 1'b1;
          end else begin
            set_len_s = set_len_s;
          end
          if (line_v != 16'hFFFF) begin
            line_v = line_v + 16'd1;
          end else begin
            line_v = line_v;
          end
        end else begin
          line_v = line_v;
        end

        if (line_start_i || line_valid_i) begin
          wd_cnt_d = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + TW'(1);
        end

        // Frame end is checked after any same-cycle line end.
        if (frame_end_i) begin
          if (line_v != 16'(g_VRES)) begin
            set_lcnt_s = 1'b1;
          end else begin
            set_lcnt_s = set_lcnt_s;
          end
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          wd_cnt_d    = '0;
          state_d     = cont_s ? ST_WAIT_FS : ST_IDLE;
        end else if (wd_cnt_d == TW'(g_TIMEOUT)) begin
          set_to_s = 1'b1;
          wd_cnt_d = '0;
          state_d  = cont_s ? ST_WAIT_FS : ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end

        beat_cnt_d = beat_v;
        line_cnt_d = line_v;
        sof_pend_d = sof_v;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d == ST_ACTIVE);
    err_len_d  = set_len_s  | (err_len_q  & ~clr_err_i);
    err_lcnt_d = set_lcnt_s | (err_lcnt_q & ~clr_err_i);
    err_to_d   = set_to_s   | (err_to_q   & ~clr_err_i);
  end

  // State, counters and all outputs registered; asynchronous reset clears everything.
  always_ff @(posedge PARALLEL_CLOCK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      line_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
      wd_cnt_q    <= '0;
      sof_pend_q  <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_lcnt_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      sof_pend_q  <= sof_pend_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_lcnt_q  <= err_lcnt_d;
      err_to_q    <= err_to_d;
    end
  end

  assign tdata_o        = tdata_q;
  assign tvalid_o       = tvalid_q;
  assign tuser_o        = tuser_q;
  assign tlast_o        = tlast_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign err_line_len_o = err_len_q;
  assign err_line_cnt_o = err_lcnt_q;
  assign err_timeout_o  = err_to_q;
  assign line_count_o   = line_cnt_q;
  assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_mipi_rx_frame_ctrl.sv
// Self-checking bench for mipi_rx_frame_ctrl with a reduced geometry
// (4 beats per line, 3 lines per frame, watchdog of 100 cycles).
// Expected beats are queued as stimulus is driven and compared as the DUT emits them.
module tb_mipi_rx_frame_ctrl;

  localparam int DW      = 8;
  localparam int NP      = 2;
  localparam int W       = DW * NP;
  localparam int HRES    = 8;
  localparam int VRES    = 3;
  localparam int TIMEOUT = 100;
  localparam int BEATS   = HRES / NP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable_i, single_shot_i, arm_i, clr_err_i;
  logic          frame_start_i, frame_end_i, line_start_i, line_end_i, line_valid_i;
  logic [W-1:0]  data_in_i;
  logic [W-1:0]  tdata_o;
  logic          tvalid_o, tuser_o, tlast_o, busy_o, frame_done_o;
  logic          err_line_len_o, err_line_cnt_o, err_timeout_o;
  logic [15:0]   line_count_o, frame_count_o;

  int n_chk  = 0;
  int n_fail = 0;
  int n_beats = 0, n_tuser = 0, n_tlast = 0, n_done = 0;
  int s_beats, s_tuser, s_tlast, s_done;
  int exp_frames = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;

  mipi_rx_frame_ctrl #(
    .g_DATAWIDTH(DW), .g_NUM_OF_PIXELS(NP), .g_HRES(HRES),
    .g_VRES(VRES), .g_TIMEOUT(TIMEOUT)
  ) dut (
    .PARALLEL_CLOCK_I(clk), .RESET_n_I(rst_n),
    .enable_i(enable_i), .single_shot_i(single_shot_i), .arm_i(arm_i),
    .clr_err_i(clr_err_i), .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
    .line_start_i(line_start_i), .line_end_i(line_end_i), .line_valid_i(line_valid_i),
    .data_in_i(data_in_i), .tdata_o(tdata_o), .tvalid_o(tvalid_o), .tuser_o(tuser_o),
    .tlast_o(tlast_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .err_line_len_o(err_line_len_o), .err_line_cnt_o(err_line_cnt_o),
    .err_timeout_o(err_timeout_o), .line_count_o(line_count_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every emitted beat, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && tvalid_o) begin
      n_beats <= n_beats + 1;
      if (tuser_o) n_tuser <= n_tuser + 1;
      if (tlast_o) n_tlast <= n_tlast + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(tdata_o), 64'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'({tdata_o, tuser_o, tlast_o}), 64'(e));
      end
    end
    if (rst_n && frame_done_o) n_done <= n_done + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_beats = n_beats; s_tuser = n_tuser; s_tlast = n_tlast; s_done = n_done;
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) cyc();
    cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1; cyc(); clr_err_i = 1'b0; cyc();
  endtask

  // One frame: odd_line gets odd_len beats, others BEATS; merge puts frame_end on the last line_end.
  task automatic send_frame(input int nlines, input int odd_line, input int odd_len,
                            input bit cap, input bit merge);
    int nb;
    bit first;
    first = cap;
    frame_start_i = 1'b1; cyc(); frame_start_i = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      line_start_i = 1'b1; cyc(); line_start_i = 1'b0;
      nb = (l == odd_line) ? odd_len : BEATS;
      for (int b = 0; b < nb; b++) begin
        line_valid_i = 1'b1;
        data_in_i    = W'($urandom);
        if (cap && b < BEATS) begin
          exp_q.push_back({data_in_i, first, (b == BEATS - 1)});
          first = 1'b0;
        end
        cyc();
      end
      line_valid_i = 1'b0;
      line_end_i   = 1'b1;
      if (merge && l == nlines - 1) frame_end_i = 1'b1;
      cyc();
      line_end_i = 1'b0;
    end
    if (!merge) begin
      frame_end_i = 1'b1; cyc();
    end
    frame_end_i = 1'b0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; enable_i = 1'b0; single_shot_i = 1'b0; arm_i = 1'b0; clr_err_i = 1'b0;
    frame_start_i = 1'b0; frame_end_i = 1'b0; line_start_i = 1'b0; line_end_i = 1'b0;
    line_valid_i = 1'b0; data_in_i = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (2) cyc();

    // Reset state
    chk("rst_tvalid", 64'(tvalid_o), 64'd0);
    chk("rst_tdata", 64'(tdata_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_errs", 64'({err_line_len_o, err_line_cnt_o, err_timeout_o}), 64'd0);
    chk("rst_counts", 64'({line_count_o, frame_count_o}), 64'd0);

    // 1. Nominal continuous frames, second one with line_end and frame_end together
    enable_i = 1'b1; repeat (3) cyc();
    snap();
    send_frame(VRES, -1, 0, 1'b1, 1'b0);
    exp_frames++;
    drain();
    chk("nom_beats", 64'(n_beats - s_beats), 64'(VRES * BEATS));
    chk("nom_tuser", 64'(n_tuser - s_tuser), 64'd1);
    chk("nom_tlast", 64'(n_tlast - s_tlast), 64'(VRES));
    chk("nom_done", 64'(n_done - s_done), 64'd1);
    chk("nom_fcnt", 64'(frame_count_o), 64'(exp_frames));
    chk("nom_lcnt", 64'(line_count_o), 64'(VRES));
    chk("nom_errs", 64'({err_line_len_o, err_line_cnt_o, err_timeout_o}), 64'd0);
    chk("nom_busy", 64'(busy_o), 64'd0);
    snap();
    send_frame(VRES, -1, 0, 1'b1, 1'b1);
    exp_frames++;
    drain();
    chk("merge_done", 64'(n_done - s_done), 64'd1);
    chk("merge_lcnt", 64'(line_count_o), 64'(VRES));
    chk("merge_errs", 64'({err_line_len_o, err_line_cnt_o}), 64'd0);

    // 2. Short and long lines
    snap();
    send_frame(VRES, 1, BEATS - 1, 1'b1, 1'b0);
    exp_frames++;
    drain();
    chk("short_tlast", 64'(n_tlast - s_tlast), 64'(VRES - 1));
    chk("short_err_len", 64'(err_line_len_o), 64'd1);
    chk("short_err_lcnt", 64'(err_line_cnt_o), 64'd0);
    pulse_clr();
    chk("short_clr", 64'(err_line_len_o), 64'd0);
    snap();
    send_frame(VRES, 1, BEATS + 2, 1'b1, 1'b0);
    exp_frames++;
    drain();
    chk("long_beats", 64'(n_beats - s_beats), 64'(VRES * BEATS));
    chk("long_err_len", 64'(err_line_len_o), 64'd1);
    pulse_clr();
    chk("long_clr", 64'(err_line_len_o), 64'd0);

    // 3. Frame with one line missing
    snap();
    send_frame(VRES - 1, -1, 0, 1'b1, 1'b0);
    exp_frames++;
    drain();
    chk("lines_err_lcnt", 64'(err_line_cnt_o), 64'd1);
    chk("lines_done", 64'(n_done - s_done), 64'd1);
    chk("lines_lcnt", 64'(line_count_o), 64'(VRES - 1));
    chk("lines_fcnt", 64'(frame_count_o), 64'(exp_frames));
    pulse_clr();
    chk("lines_clr", 64'(err_line_cnt_o), 64'd0);

    // 4. Single shot: one arm, two frames offered
    enable_i = 1'b0; repeat (3) cyc();
    single_shot_i = 1'b1; enable_i = 1'b1; repeat (3) cyc();
    chk("ss_idle_busy", 64'(busy_o), 64'd0);
    arm_i = 1'b1; cyc(); arm_i = 1'b0; cyc();
    snap();
    send_frame(VRES, -1, 0, 1'b1, 1'b0);
    exp_frames++;
    send_frame(VRES, -1, 0, 1'b0, 1'b0);
    drain();
    chk("ss_beats", 64'(n_beats - s_beats), 64'(VRES * BEATS));
    chk("ss_done", 64'(n_done - s_done), 64'd1);
    chk("ss_fcnt", 64'(frame_count_o), 64'(exp_frames));
    chk("ss_busy", 64'(busy_o), 64'd0);
    single_shot_i = 1'b0; repeat (3) cyc();

    // 5. Stall mid-frame until the watchdog expires
    snap();
    frame_start_i = 1'b1; cyc(); frame_start_i = 1'b0;
    line_start_i = 1'b1; cyc(); line_start_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      line_valid_i = 1'b1; data_in_i = W'($urandom);
      exp_q.push_back({data_in_i, (b == 0), (b == BEATS - 1)});
      cyc();
    end
    line_valid_i = 1'b0;
    line_end_i = 1'b1; cyc(); line_end_i = 1'b0;
    repeat (50) cyc();
    chk("stall_busy_early", 64'(busy_o), 64'd1);
    chk("stall_to_early", 64'(err_timeout_o), 64'd0);
    repeat (60) cyc();
    chk("stall_err_to", 64'(err_timeout_o), 64'd1);
    chk("stall_busy", 64'(busy_o), 64'd0);
    chk("stall_done", 64'(n_done - s_done), 64'd0);
    chk("stall_fcnt", 64'(frame_count_o), 64'(exp_frames));
    drain();
    pulse_clr();
    chk("stall_clr", 64'(err_timeout_o), 64'd0);

    // 6. Reset asserted mid-line, then capture resumes at the next frame start
    frame_start_i = 1'b1; cyc(); frame_start_i = 1'b0;
    line_start_i = 1'b1; cyc(); line_start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      line_valid_i = 1'b1; data_in_i = W'($urandom);
      exp_q.push_back({data_in_i, (b == 0), 1'b0});
      cyc();
    end
    line_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_frames = 0;
    chk("mrst_tvalid", 64'(tvalid_o), 64'd0);
    chk("mrst_busy", 64'(busy_o), 64'd0);
    chk("mrst_counts", 64'({line_count_o, frame_count_o}), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1; repeat (2) cyc();
    snap();
    for (int b = 0; b < 3; b++) begin
      line_valid_i = 1'b1; data_in_i = W'($urandom); cyc();
    end
    line_valid_i = 1'b0; cyc();
    send_frame(VRES, -1, 0, 1'b1, 1'b0);
    exp_frames++;
    drain();
    chk("resume_beats", 64'(n_beats - s_beats), 64'(VRES * BEATS));
    chk("resume_tuser", 64'(n_tuser - s_tuser), 64'd1);
    chk("resume_fcnt", 64'(frame_count_o), 64'(exp_frames));
    chk("resume_errs", 64'({err_line_len_o, err_line_cnt_o, err_timeout_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
